// File: rtl/calc_pkg.sv
// Shared calculator types: key codes, keypad scan classes, scanner FSM states
// and small helpers for decoding active-low column returns.
package calc_pkg;

  typedef logic [3:0] key_code_t;

  // Result of one full keypad scan (all four rows).
  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_class_e;

  // Keypad scanner debounce FSM.
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } kp_state_e;

  // Key layout: code = row*4 + col.
  localparam key_code_t KEY_0 = 4'h0;
  localparam key_code_t KEY_1 = 4'h1;
  localparam key_code_t KEY_2 = 4'h2;
  localparam key_code_t KEY_3 = 4'h3;
  localparam key_code_t KEY_4 = 4'h4;
  localparam key_code_t KEY_5 = 4'h5;
  localparam key_code_t KEY_6 = 4'h6;
  localparam key_code_t KEY_7 = 4'h7;
  localparam key_code_t KEY_8 = 4'h8;
  localparam key_code_t KEY_9 = 4'h9;
  localparam key_code_t KEY_A = 4'hA;
  localparam key_code_t KEY_B = 4'hB;
  localparam key_code_t KEY_C = 4'hC;
  localparam key_code_t KEY_D = 4'hD;
  localparam key_code_t KEY_E = 4'hE;
  localparam key_code_t KEY_F = 4'hF;

  // Number of low (pressed) bits in an active-low column vector.
  function automatic logic [2:0] count_low(input logic [3:0] cols);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~cols[i]};
    end
    return n;
  endfunction

  // Index of the lowest-numbered low column (meaningful when exactly one is low).
  function automatic logic [1:0] low_index(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width and
// reset value so it can also front any asynchronous push button.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: drives one row at a time, samples the
// synchronized columns at the end of each row period, classifies each full
// scan and debounces presses/releases over DEBOUNCE_SCANS identical scans.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,  // cycles per row, >= 4
  parameter int DEBOUNCE_SCANS = 8      // identical scans to accept, >= 2
) (
  input  logic      clk,
  input  logic      rst_n,
  output logic [3:0] row_drive,
  input  logic [3:0] col_sense,
  output key_code_t  key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  // Synchronized column returns; idle (no key) is all ones.
  logic [3:0] cols_sync;

  sync_2ff #(
    .WIDTH    (4),
    .RESET_VAL(4'b1111)
  ) u_col_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (col_sense),
    .q    (cols_sync)
  );

  // Scan datapath state.
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;    // lows seen this scan, saturates at 2
  key_code_t     acc_code_q, acc_code_d;  // code of the first low seen

  logic          row_end;
  logic          scan_end;
  logic [2:0]    low_n;
  key_code_t     row_code;
  logic [1:0]    merged_cnt;
  key_code_t     merged_code;
  scan_class_e   scan_cls;

  // Row timing and per-scan accumulation of the sampled columns.
  always_comb begin
    row_end     = (timer_q == TW'(SCAN_DIV - 1));
    scan_end    = row_end && (row_q == 2'd3);
    low_n       = count_low(cols_sync);
    row_code    = {row_q, low_index(cols_sync)};
    merged_cnt  = acc_cnt_q;
    merged_code = acc_code_q;
    if (row_end) begin
      if (low_n == 3'd1) begin
        if (acc_cnt_q == 2'd0) begin
          merged_cnt  = 2'd1;
          merged_code = row_code;
        end else begin
          merged_cnt = 2'd2;
        end
      end else if (low_n > 3'd1) begin
        merged_cnt = 2'd2;
      end
    end
    // Classification includes the row-3 sample taken on this same cycle.
    if (merged_cnt == 2'd0)      scan_cls = SCAN_NONE;
    else if (merged_cnt == 2'd1) scan_cls = SCAN_SINGLE;
    else                         scan_cls = SCAN_MULTI;

    timer_d    = row_end ? '0 : timer_q + TW'(1);
    row_d      = row_end ? row_q + 2'd1 : row_q;
    acc_cnt_d  = scan_end ? 2'd0 : merged_cnt;
    acc_code_d = scan_end ? KEY_0 : merged_code;
  end

  // Scan datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q    <= '0;
      row_q      <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= KEY_0;
    end else begin
      timer_q    <= timer_d;
      row_q      <= row_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  // Row select changes only when row_q steps, one bit low at a time.
  assign row_drive = ~(4'b0001 << row_q);

  // Debounce FSM state and registered outputs.
  kp_state_e     state_q, state_d;
  key_code_t     cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  key_code_t     key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  // Next-state logic; the FSM only moves on the edge that ends a scan.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_inc     = cnt_q + CW'(1);
    if (scan_end) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_cls == SCAN_SINGLE) begin
            state_d = ST_DEB_PRESS;
            cand_d  = merged_code;
            cnt_d   = CW'(1);
          end
        end
        ST_DEB_PRESS: begin
          if (scan_cls == SCAN_SINGLE && merged_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_d     = ST_PRESSED;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end
          end else if (scan_cls == SCAN_SINGLE) begin
            cand_d = merged_code;
            cnt_d  = CW'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          // Extra or changed keys while held never re-trigger.
          if (scan_cls == SCAN_NONE) begin
            state_d = ST_DEB_RELEASE;
            cnt_d   = CW'(1);
          end
        end
        ST_DEB_RELEASE: begin
          if (scan_cls == SCAN_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_d    = ST_IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= KEY_0;
      cnt_q       <= '0;
      key_code_q  <= KEY_0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scans).
// A keypad model pulls columns low from row_drive; expected key strobes
// ({cycle, code}) are queued as stimulus is planned and popped on key_valid.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_drive;
  logic [3:0] col_sense;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys_down = 16'h0;  // bit (row*4+col) = key closed
  int          cyc;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];           // {cycle[11:0], code[3:0]}

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_drive(row_drive),
    .col_sense(col_sense),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Clock and cycle counter (cycle 0 is the first cycle after reset release).
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Keypad model: a driven row with a closed key pulls that column low.
  always_comb begin
    col_sense = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_drive[r] && keys_down[r*4+c]) col_sense[c] = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    logic [15:0] e;
    logic [3:0]  exp_row;
    if (rst_n) begin
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", 32'(key_code), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("valid_cycle", 32'(cyc), 32'(e[15:4]));
          check_eq("valid_code", 32'(key_code), 32'(e[3:0]));
          check_eq("held_at_valid", 32'(key_held), 32'd1);
        end
      end
      if (cyc % SCAN_DIV == 0) begin
        exp_row = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
        check_eq("row_drive", 32'(row_drive), 32'(exp_row));
      end
    end
  end

  // Driver tasks.
  task automatic expect_key(input int at_cycle, input logic [3:0] code);
    exp_q.push_back({at_cycle[11:0], code});
  endtask

  task automatic check_reset_vals();
    check_eq("rst_row_drive", 32'(row_drive), 32'hE);
    check_eq("rst_key_code", 32'(key_code), 32'd0);
    check_eq("rst_key_valid", 32'(key_valid), 32'd0);
    check_eq("rst_key_held", 32'(key_held), 32'd0);
  endtask

  task automatic do_reset(input logic [15:0] keys);
    rst_n = 1'b0;
    keys_down = keys;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (cyc != target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) check_eq("run_to_timeout", 32'(cyc), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Key 9 (row 2, col 1) held from reset release: strobe in cycle 48.
    do_reset(16'h0001 << 9);
    expect_key(48, 4'd9);
    run_to(47);
    check_eq("s1_held_47", 32'(key_held), 32'd0);
    run_to(48);
    check_eq("s1_held_48", 32'(key_held), 32'd1);
    check_eq("s1_code_48", 32'(key_code), 32'd9);
    run_to(60);

    // Key 9 bouncing one scan on / one off, then stable; then clean release.
    do_reset(16'h0001 << 9);
    run_to(16);  keys_down = 16'h0;
    run_to(32);  keys_down = 16'h0001 << 9;
    run_to(48);  keys_down = 16'h0;
    run_to(64);  keys_down = 16'h0001 << 9;
    expect_key(112, 4'd9);
    run_to(111);
    check_eq("s2_held_111", 32'(key_held), 32'd0);
    run_to(112);
    check_eq("s2_held_112", 32'(key_held), 32'd1);
    run_to(144); keys_down = 16'h0;       // first empty scan is scan 9
    run_to(191);
    check_eq("s3_held_191", 32'(key_held), 32'd1);
    run_to(192);
    check_eq("s3_held_192", 32'(key_held), 32'd0);
    run_to(200);
    check_eq("s3_code_kept", 32'(key_code), 32'd9);

    // Keys 5 and 6 together (same row): no strobe until 6 lifts.
    do_reset((16'h0001 << 5) | (16'h0001 << 6));
    run_to(48);  keys_down = 16'h0001 << 5;
    expect_key(96, 4'd5);
    run_to(95);
    check_eq("s4_held_95", 32'(key_held), 32'd0);
    run_to(96);
    check_eq("s4_code_96", 32'(key_code), 32'd5);
    run_to(100);

    // Key 3 held, key 12 added, 3 lifted: no re-trigger until full release.
    do_reset(16'h0001 << 3);
    expect_key(48, 4'd3);
    run_to(64);  keys_down = (16'h0001 << 3) | (16'h0001 << 12);
    run_to(96);  keys_down = 16'h0001 << 12;
    run_to(160); keys_down = 16'h0;
    run_to(207);
    check_eq("s5_held_207", 32'(key_held), 32'd1);
    check_eq("s5_code_207", 32'(key_code), 32'd3);
    run_to(208);
    check_eq("s5_held_208", 32'(key_held), 32'd0);
    keys_down = 16'h0001 << 12;
    expect_key(256, 4'd12);
    run_to(256);
    check_eq("s5_code_256", 32'(key_code), 32'd12);
    run_to(260);

    // Reset pulse during press debounce (count 2) restarts everything.
    do_reset(16'h0);
    keys_down = 16'h0001 << 9;
    run_to(40);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_key(48, 4'd9);
    run_to(47);
    check_eq("s6_held_47", 32'(key_held), 32'd0);
    run_to(48);
    check_eq("s6_held_48", 32'(key_held), 32'd1);
    run_to(60);

    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the multiplexed display driver. It scans a 4x4 active-low matrix keypad one row at a time, synchronizes and debounces the column returns, and reports each debounced key press as a 4-bit code with a one-cycle valid strobe. Its key codes feed the calculator's operand and operation entry logic in the same way that the display path consumes ALU results.

## Interface
Parameters:
- SCAN_DIV, default 1000: clock cycles each row is driven. Must be ≥ 4.
- DEBOUNCE_SCANS, default 8: consecutive identical full-scan results needed to accept a press or a release. Must be ≥ 2.

Ports:
- clk, input, 1: single system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- row_drive, output, 4: active-low one-hot row select. Row r is driven when bit r = 0.
- col_sense, input, 4: raw active-low column returns, externally pulled up, asynchronous to clk.
- key_code, output, 4: code of the last accepted key, row*4 + col.
- key_valid, output, 1: one-cycle pulse when a press is accepted.
- key_held, output, 1: high from acceptance until the release is accepted.

## Operation
- col_sense passes through a 2-flop synchronizer. Reset value of the synchronizer is 4'b1111.
- Row counter cycles 0→1→2→3→0. Each row is held for SCAN_DIV cycles. row_drive = ~(1 << row).
- Columns are sampled on the last cycle of each row period, which gives settling time plus the synchronizer delay.
- Scan accumulator: a scan covers rows 0..3. At the end of row 3 the scan is classified:
  - NONE: no column low on any row.
  - SINGLE(code): exactly one (row,col) low.
  - MULTI: more than one low.
- FSM states:
  - IDLE
    - SINGLE(c) → DEB_PRESS, with candidate = c and count = 1.
    - NONE or MULTI → stay.
  - DEB_PRESS
    - SINGLE(candidate) → count+1.
      - When count reaches DEBOUNCE_SCANS: go to PRESSED, key_code ← candidate, key_valid pulses, key_held ← 1.
    - SINGLE(other) → restart with candidate = other and count = 1.
    - NONE or MULTI → IDLE.
  - PRESSED
    - NONE → DEB_RELEASE, count = 1.
    - SINGLE (any code) or MULTI → stay. No re-trigger, no auto-repeat.
  - DEB_RELEASE
    - NONE → count+1.
      - When count reaches DEBOUNCE_SCANS: go to IDLE, key_held ← 0.
    - SINGLE or MULTI → PRESSED.
- key_code holds its value after release until the next accepted press.
- Debounce counter width is $clog2(DEBOUNCE_SCANS+1). Row timer width is $clog2(SCAN_DIV).

## Timing
- Reset values:
  - row_drive = 4'b1110 (row 0)
  - key_code = 0, key_valid = 0, key_held = 0
  - FSM = IDLE; row timer, row counter and debounce count = 0
- After rst_n deasserts, the first cycle is cycle 0. Scan k occupies cycles 16k..16k+15 for SCAN_DIV = 4.
- Classification and FSM update happen on the clock edge that ends a scan.
- key_valid is high for exactly the one cycle following the edge that completes the debounce count.
- key_held rises in the same cycle as key_valid.
- Press-to-strobe latency: at most (DEBOUNCE_SCANS+1) scans + 3 cycles.
- Asserting rst_n low mid-scan or mid-debounce immediately forces all reset values. Scanning restarts at row 0.
- row_drive changes only on row-period boundaries and never has two bits low at once.

## Structure
- Shared package calc_pkg holds:
  - typedef key_code_t (logic [3:0])
  - scan-class enum (NONE, SINGLE, MULTI)
  - FSM state enum
  - named key constants (KEY_0..KEY_F layout)
- One sub-module: sync_2ff, a parameterized-width 2-flop synchronizer with asynchronous active-low reset and reset value parameter. It is reused for any other asynchronous button input.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_SCANS = 3, so one scan is 16 cycles. The keypad model drives col_sense from row_drive.

- Key (row 2, col 1) held from reset release → key_valid pulses only in cycle 48, key_code = 9, key_held = 1 from cycle 48.
- Key 9 bounces (closed 1 scan, open 1 scan, repeated) → no key_valid. Then stable for 3 scans → a single pulse.
- Key 9 held, then released cleanly → key_held falls exactly 3 scans after the first empty scan. key_code stays 9 with no extra pulse.
- Keys 5 and 6 pressed together from IDLE → no key_valid. Release 6 leaving 5 stable → key_valid with key_code = 5.
- While key 3 is held in PRESSED, key 12 is also pressed, then 3 is released → no second key_valid until all keys are released and key 12 is re-pressed.
- rst_n pulsed low during DEB_PRESS (count = 2) → all outputs at reset values, row_drive = 1110. A subsequent stable press needs the full 3 scans.
